// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : shared video-timing constants for the VGA timing generator.
//           Holds the 640x480@60 set (used by default), its derived totals,
//           the default counter width and divider ratio, plus an 800x600@60
//           set kept for later reuse.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Sum of the four segments of one axis (active + porches + sync).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480@60, 25 MHz pixel clock derived from a 100 MHz board clock.
    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL  = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    localparam int VGA_CNT_W    = 10;

    // 800x600@60 (40 MHz pixel clock), spare set for a later mode.
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam int SVGA_H_TOTAL  = axis_total(SVGA_H_ACTIVE, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP);
    localparam int SVGA_V_TOTAL  = axis_total(SVGA_V_ACTIVE, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP);
    localparam int SVGA_CNT_W    = 11;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Purpose : one display axis (horizontal or vertical). Counts 0..TOTAL-1 on
//           each enabled cycle and decodes the visible window, the active-low
//           sync pulse and a start-of-blanking strobe from the NEXT count, so
//           every registered output changes in the same cycle as the count.
// Ports   :
//   clk         in   clock
//   rst         in   asynchronous active-high reset (count -> TOTAL-1)
//   en          in   advance the count by one this cycle
//   cnt         out  current position [CNT_W]
//   wrap        out  combinational: en is high and the count is at TOTAL-1
//   active      out  position is inside the visible window
//   sync_n      out  active-low sync, low for positions ACTIVE+FP..+SYNC-1
//   blank_start out  one-cycle pulse on the cycle the count becomes ACTIVE
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CNT_W  = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync_n,
    output logic             blank_start
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_C     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             sync_n_q, sync_n_d;
    logic             blank_q, blank_d;
    logic             at_last;

    always_comb begin
        at_last = (cnt_q == LAST_C);
        cnt_d   = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
        // Decode from the next count so outputs line up with cnt_q.
        active_d = (cnt_d < ACT_C);
        sync_n_d = !((cnt_d >= SYNC_LO_C) && (cnt_d < SYNC_HI_C));
        // Gated by en: the count only "becomes" ACTIVE on an advancing cycle.
        blank_d  = en && (cnt_d == ACT_C);
    end

    assign wrap = en && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= LAST_C;
            active_q <= 1'b0;
            sync_n_q <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            sync_n_q <= sync_n_d;
            blank_q  <= blank_d;
        end
    end

    assign cnt         = cnt_q;
    assign active      = active_q;
    assign sync_n      = sync_n_q;
    assign blank_start = blank_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : VGA timing front end for the rotozoom pixel generator. Divides
//           clk down to the pixel rate, runs horizontal/vertical position
//           counters and drives sync pins, display enable, coordinates and
//           single-cycle line/frame strobes.
// Ports   :
//   clk           in   board clock
//   rst           in   asynchronous active-high reset
//   pix_tick      out  one-clk pixel enable every CLK_DIV clocks
//   hsync_n       out  horizontal sync, active low
//   vsync_n       out  vertical sync, active low
//   de            out  (x,y) inside the visible area
//   x, y          out  current horizontal / vertical position [CNT_W]
//   line_strobe   out  one-clk pulse when x becomes H_ACTIVE (every line)
//   frame_strobe  out  one-clk pulse when (x,y) becomes (0,V_ACTIVE)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_tick,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_strobe,
    output logic             frame_strobe
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Clock divider. tick_d is the next-state pixel enable; the counters
    // advance on the same edge that raises pix_tick, so coordinates and
    // pix_tick are aligned. With CLK_DIV=1 div stays at 0 and ticks always.
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_d;
    logic             pix_tick_q;

    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_tick_q <= tick_d;
        end
    end

    logic h_wrap;
    logic h_active, v_active;
    logic unused_v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (tick_d),
        .cnt         (x),
        .wrap        (h_wrap),
        .active      (h_active),
        .sync_n      (hsync_n),
        .blank_start (line_strobe)
    );

    // Vertical axis advances once per line, on the tick that wraps h. Its
    // blank_start therefore fires exactly when (h,v) becomes (0,V_ACTIVE).
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (h_wrap),
        .cnt         (y),
        .wrap        (unused_v_wrap),
        .active      (v_active),
        .sync_n      (vsync_n),
        .blank_start (frame_strobe)
    );

    // Both terms are flops updated on the same edge, so de is clean.
    assign de       = h_active && v_active;
    assign pix_tick = pix_tick_q;

endmodule
